// File: rtl/lane_motion_scheduler_pkg.sv
// Shared constants, lane configuration record and sequencer state type
// for the per-frame lane motion scheduler.
package lane_motion_scheduler_pkg;

    localparam int SCREEN_W  = 640;
    localparam int OBJ_W     = 80;
    localparam int TRACK_LEN = SCREEN_W + OBJ_W;
    localparam int TOP_Y     = 80;
    localparam int LANE_H    = 40;
    localparam int NUM_LANES = 8;
    localparam int MAX_OBJS  = 4;

    typedef struct packed {
        logic [3:0] speed;
        logic       dir;
        logic [2:0] count;
        logic [7:0] spacing;
    } lane_cfg_t;

    typedef enum logic [1:0] {StIdle, StUpdate, StCommit} sched_state_t;

    // Lane 7 is the top row; lanes step downwards by LANE_H.
    function automatic logic [10:0] lane_y(input logic [2:0] lane);
        return 11'(TOP_Y + (NUM_LANES - 1 - int'(lane)) * LANE_H);
    endfunction

endpackage

// File: rtl/lane_motion_scheduler_step.sv
// Combinational single-slot X step: advance by speed in the lane direction,
// wrapping around the off-screen track in 11-bit two's complement.
module lane_motion_scheduler_step
    import lane_motion_scheduler_pkg::*;
(
    input  logic [10:0] i_x,
    input  logic [3:0]  i_speed,
    input  logic        i_dir,
    output logic [10:0] o_x
);

    localparam logic signed [10:0] RightLim = 11'(SCREEN_W);
    localparam logic signed [10:0] LeftLim  = 11'(-OBJ_W);
    localparam logic [10:0]        Wrap     = 11'(TRACK_LEN);

    logic [10:0] w_fwd;
    logic [10:0] w_back;

    always_comb begin
        w_fwd  = i_x + {7'd0, i_speed};
        w_back = i_x - {7'd0, i_speed};
        if (!i_dir) begin
            o_x = ($signed(w_fwd) >= RightLim) ? w_fwd - Wrap : w_fwd;
        end else begin
            o_x = ($signed(w_back) < LeftLim) ? w_back + Wrap : w_back;
        end
    end

endmodule

// File: rtl/lane_motion_scheduler.sv
// Per-frame motion sequencer: steps 8 lanes x 4 slots into a shadow bank one
// slot per cycle, then commits the whole bank to the outputs in one cycle.
module lane_motion_scheduler
    import lane_motion_scheduler_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             frame_tick,
    input  logic             pause,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_lane,
    input  logic [3:0]       cfg_speed,
    input  logic             cfg_dir,
    input  logic [2:0]       cfg_count,
    input  logic [7:0]       cfg_spacing,
    output logic             cfg_ready,
    output logic [3:0][10:0] Car_Row1_X,
    output logic [3:0][10:0] Car_Row2_X,
    output logic [3:0][10:0] Car_Row3_X,
    output logic [3:0][10:0] Car_Row4_X,
    output logic [3:0][10:0] Car_Row1_Y,
    output logic [3:0][10:0] Car_Row2_Y,
    output logic [3:0][10:0] Car_Row3_Y,
    output logic [3:0][10:0] Car_Row4_Y,
    output logic [3:0][10:0] LPad_Row1_X,
    output logic [3:0][10:0] LPad_Row2_X,
    output logic [3:0][10:0] LPad_Row3_X,
    output logic [3:0][10:0] LPad_Row4_X,
    output logic [3:0][10:0] LPad_Row1_Y,
    output logic [3:0][10:0] LPad_Row2_Y,
    output logic [3:0][10:0] LPad_Row3_Y,
    output logic [3:0][10:0] LPad_Row4_Y,
    output logic [2:0]       Row1_Number_Cars,
    output logic [2:0]       Row2_Number_Cars,
    output logic [2:0]       Row3_Number_Cars,
    output logic [2:0]       Row4_Number_Cars,
    output logic [2:0]       Row1_Number_LPads,
    output logic [2:0]       Row2_Number_LPads,
    output logic [2:0]       Row3_Number_LPads,
    output logic [2:0]       Row4_Number_LPads,
    output logic             update_done,
    output logic             overrun
);

    sched_state_t r_state;
    sched_state_t w_state_d;

    lane_cfg_t                   r_cfg [NUM_LANES];
    logic [MAX_OBJS-1:0][10:0]   r_x   [NUM_LANES];
    logic [MAX_OBJS-1:0][10:0]   r_sx  [NUM_LANES];
    logic [4:0]                  r_idx;
    logic                        r_pause;
    logic                        r_done;
    logic                        r_overrun;

    logic [2:0]                  w_lane;
    logic [1:0]                  w_slot;
    logic [10:0]                 w_cur_x;
    logic [10:0]                 w_step_x;
    logic [2:0]                  w_count;
    logic [MAX_OBJS-1:0][10:0]   w_spawn;

    assign w_lane  = r_idx[4:2];
    assign w_slot  = r_idx[1:0];
    assign w_cur_x = r_x[w_lane][w_slot];
    assign w_count = (cfg_count > 3'd4) ? 3'd4 : cfg_count;

    always_comb begin
        w_spawn = '0;
        for (int k = 0; k < MAX_OBJS; k++) begin
            w_spawn[k] = 11'(k) * {3'b000, cfg_spacing};
        end
    end

    lane_motion_scheduler_step u_step (
        .i_x     (w_cur_x),
        .i_speed (r_cfg[w_lane].speed),
        .i_dir   (r_cfg[w_lane].dir),
        .o_x     (w_step_x)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // A config write in IDLE takes priority over a coincident tick.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:   if (frame_tick && !cfg_we) w_state_d = StUpdate;
            StUpdate: if (r_idx == 5'd31) w_state_d = StCommit;
            StCommit: w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    always_comb begin
        cfg_ready = (r_state == StIdle);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                r_cfg[l] <= '{speed: 4'd1, dir: 1'(l % 2), count: 3'd0, spacing: 8'd0};
                r_x[l]   <= '0;
                r_sx[l]  <= '0;
            end
            r_idx     <= '0;
            r_pause   <= 1'b0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (frame_tick && r_state != StIdle) r_overrun <= 1'b1;
            unique case (r_state)
                StIdle: begin
                    if (cfg_we) begin
                        r_cfg[cfg_lane] <= '{speed: cfg_speed, dir: cfg_dir, count: w_count,
                                             spacing: cfg_spacing};
                        r_x[cfg_lane]   <= w_spawn;
                        r_sx[cfg_lane]  <= w_spawn;
                    end else if (frame_tick) begin
                        r_idx   <= '0;
                        r_pause <= pause;
                    end
                end
                StUpdate: begin
                    r_sx[w_lane][w_slot] <= r_pause ? w_cur_x : w_step_x;
                    r_idx                <= r_idx + 5'd1;
                end
                StCommit: begin
                    r_x    <= r_sx;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Car_Row1_X  = r_x[0];
    assign Car_Row2_X  = r_x[1];
    assign Car_Row3_X  = r_x[2];
    assign Car_Row4_X  = r_x[3];
    assign LPad_Row1_X = r_x[4];
    assign LPad_Row2_X = r_x[5];
    assign LPad_Row3_X = r_x[6];
    assign LPad_Row4_X = r_x[7];

    assign Car_Row1_Y  = {MAX_OBJS{lane_y(3'd0)}};
    assign Car_Row2_Y  = {MAX_OBJS{lane_y(3'd1)}};
    assign Car_Row3_Y  = {MAX_OBJS{lane_y(3'd2)}};
    assign Car_Row4_Y  = {MAX_OBJS{lane_y(3'd3)}};
    assign LPad_Row1_Y = {MAX_OBJS{lane_y(3'd4)}};
    assign LPad_Row2_Y = {MAX_OBJS{lane_y(3'd5)}};
    assign LPad_Row3_Y = {MAX_OBJS{lane_y(3'd6)}};
    assign LPad_Row4_Y = {MAX_OBJS{lane_y(3'd7)}};

    assign Row1_Number_Cars  = r_cfg[0].count;
    assign Row2_Number_Cars  = r_cfg[1].count;
    assign Row3_Number_Cars  = r_cfg[2].count;
    assign Row4_Number_Cars  = r_cfg[3].count;
    assign Row1_Number_LPads = r_cfg[4].count;
    assign Row2_Number_LPads = r_cfg[5].count;
    assign Row3_Number_LPads = r_cfg[6].count;
    assign Row4_Number_LPads = r_cfg[7].count;

    assign update_done = r_done;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_lane_motion_scheduler.sv
// Bench for lane_motion_scheduler: table of lane configs plus hand sequences,
// with frame snapshots predicted by a behavioural model and queued per tick.
module tb_lane_motion_scheduler;

    logic Clk = 1'b0;
    logic Reset, frame_tick, pause, cfg_we;
    logic [2:0] cfg_lane;
    logic [3:0] cfg_speed;
    logic cfg_dir;
    logic [2:0] cfg_count;
    logic [7:0] cfg_spacing;
    logic cfg_ready, update_done, overrun;
    logic [3:0][10:0] Car_Row1_X, Car_Row2_X, Car_Row3_X, Car_Row4_X;
    logic [3:0][10:0] Car_Row1_Y, Car_Row2_Y, Car_Row3_Y, Car_Row4_Y;
    logic [3:0][10:0] LPad_Row1_X, LPad_Row2_X, LPad_Row3_X, LPad_Row4_X;
    logic [3:0][10:0] LPad_Row1_Y, LPad_Row2_Y, LPad_Row3_Y, LPad_Row4_Y;
    logic [2:0] Row1_Number_Cars, Row2_Number_Cars, Row3_Number_Cars, Row4_Number_Cars;
    logic [2:0] Row1_Number_LPads, Row2_Number_LPads, Row3_Number_LPads, Row4_Number_LPads;

    always #5 Clk = ~Clk;

    lane_motion_scheduler dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .pause(pause), .cfg_we(cfg_we),
        .cfg_lane(cfg_lane), .cfg_speed(cfg_speed), .cfg_dir(cfg_dir), .cfg_count(cfg_count),
        .cfg_spacing(cfg_spacing), .cfg_ready(cfg_ready),
        .Car_Row1_X(Car_Row1_X), .Car_Row2_X(Car_Row2_X), .Car_Row3_X(Car_Row3_X),
        .Car_Row4_X(Car_Row4_X), .Car_Row1_Y(Car_Row1_Y), .Car_Row2_Y(Car_Row2_Y),
        .Car_Row3_Y(Car_Row3_Y), .Car_Row4_Y(Car_Row4_Y),
        .LPad_Row1_X(LPad_Row1_X), .LPad_Row2_X(LPad_Row2_X), .LPad_Row3_X(LPad_Row3_X),
        .LPad_Row4_X(LPad_Row4_X), .LPad_Row1_Y(LPad_Row1_Y), .LPad_Row2_Y(LPad_Row2_Y),
        .LPad_Row3_Y(LPad_Row3_Y), .LPad_Row4_Y(LPad_Row4_Y),
        .Row1_Number_Cars(Row1_Number_Cars), .Row2_Number_Cars(Row2_Number_Cars),
        .Row3_Number_Cars(Row3_Number_Cars), .Row4_Number_Cars(Row4_Number_Cars),
        .Row1_Number_LPads(Row1_Number_LPads), .Row2_Number_LPads(Row2_Number_LPads),
        .Row3_Number_LPads(Row3_Number_LPads), .Row4_Number_LPads(Row4_Number_LPads),
        .update_done(update_done), .overrun(overrun)
    );

    logic [351:0] w_all_x, w_all_y;
    logic [23:0]  w_all_cnt;
    assign w_all_x = {LPad_Row4_X, LPad_Row3_X, LPad_Row2_X, LPad_Row1_X,
                      Car_Row4_X, Car_Row3_X, Car_Row2_X, Car_Row1_X};
    assign w_all_y = {LPad_Row4_Y, LPad_Row3_Y, LPad_Row2_Y, LPad_Row1_Y,
                      Car_Row4_Y, Car_Row3_Y, Car_Row2_Y, Car_Row1_Y};
    assign w_all_cnt = {Row4_Number_LPads, Row3_Number_LPads, Row2_Number_LPads,
                        Row1_Number_LPads, Row4_Number_Cars, Row3_Number_Cars,
                        Row2_Number_Cars, Row1_Number_Cars};

    typedef struct packed {
        int lane; int speed; int dir; int count; int spacing; int ticks; int exp_cnt;
        logic [3:0][10:0] exp_x;
    } vec_t;

    typedef struct packed {
        logic [351:0] x;
        logic [23:0]  cnt;
    } snap_t;

    snap_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    logic [10:0] m_x [8][4];
    int m_speed [8];
    int m_dir [8];
    int m_cnt [8];

    task automatic check(input string name, input logic [351:0] act, input logic [351:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] model_step(input logic [10:0] x, input int speed,
                                               input int dir);
        int v;
        v = (x >= 11'd1024) ? int'(x) - 2048 : int'(x);
        v = (dir == 0) ? v + speed : v - speed;
        v = ((v % 2048) + 2048) % 2048;
        if (v >= 1024) v -= 2048;
        if (dir == 0 && v >= 640) v -= 720;
        if (dir != 0 && v < -80) v += 720;
        return 11'(v);
    endfunction

    function automatic logic [351:0] model_x();
        logic [351:0] v = '0;
        for (int l = 0; l < 8; l++)
            for (int s = 0; s < 4; s++) v[l*44 + s*11 +: 11] = m_x[l][s];
        return v;
    endfunction

    function automatic logic [23:0] model_cnt();
        logic [23:0] v = '0;
        for (int l = 0; l < 8; l++) v[l*3 +: 3] = 3'(m_cnt[l]);
        return v;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < 8; l++) begin
            m_speed[l] = 1; m_dir[l] = l % 2; m_cnt[l] = 0;
            for (int s = 0; s < 4; s++) m_x[l][s] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge Clk); Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        sb.delete();
    endtask

    task automatic apply_cfg(input int lane, input int speed, input int dir, input int count,
                             input int spacing, input bit with_tick);
        @(negedge Clk);
        cfg_we = 1'b1; cfg_lane = 3'(lane); cfg_speed = 4'(speed); cfg_dir = 1'(dir);
        cfg_count = 3'(count); cfg_spacing = 8'(spacing); frame_tick = with_tick;
        @(negedge Clk);
        cfg_we = 1'b0; frame_tick = 1'b0;
        m_speed[lane] = speed; m_dir[lane] = dir; m_cnt[lane] = (count > 4) ? 4 : count;
        for (int k = 0; k < 4; k++) m_x[lane][k] = 11'(k * spacing);
        check("respawn_x", w_all_x, model_x());
        check("respawn_cnt", 352'(w_all_cnt), 352'(model_cnt()));
    endtask

    // Drives one tick and waits for its commit; optional mid-frame stimulus at a
    // given cycle offset (-1 = none).
    task automatic run_frame(input bit p, input int tick_at, input int cfg_at, input int rst_at);
        snap_t exp;
        logic [351:0] x0;
        logic [23:0] c0;
        int lat, done_at;
        bit unstable;
        if (!p)
            for (int l = 0; l < 8; l++)
                for (int s = 0; s < 4; s++)
                    m_x[l][s] = model_step(m_x[l][s], m_speed[l], m_dir[l]);
        exp.x = model_x(); exp.cnt = model_cnt();
        sb.push_back(exp);
        @(negedge Clk); frame_tick = 1'b1; pause = p;
        @(negedge Clk); frame_tick = 1'b0; pause = 1'b0;
        x0 = w_all_x; c0 = w_all_cnt;
        lat = 0; done_at = -1; unstable = 1'b0;
        while (lat <= 40 && done_at < 0) begin
            if (update_done) begin
                done_at = lat;
            end else begin
                if ((rst_at < 0 || lat <= rst_at) && (w_all_x !== x0 || w_all_cnt !== c0))
                    unstable = 1'b1;
                if (lat == 5) check("busy_cfg_ready", 352'(cfg_ready), 352'(0));
                frame_tick = (lat == tick_at); cfg_we = (lat == cfg_at); Reset = (lat == rst_at);
                cfg_lane = 3'd2; cfg_speed = 4'd9; cfg_dir = 1'b1; cfg_count = 3'd3;
                cfg_spacing = 8'd77;
                @(negedge Clk); lat++;
                frame_tick = 1'b0; cfg_we = 1'b0; Reset = 1'b0;
                if (rst_at >= 0 && lat == rst_at + 1) begin
                    check("rst_mid_x", w_all_x, '0);
                    check("rst_mid_cnt", 352'(w_all_cnt), '0);
                    check("rst_mid_ready", 352'(cfg_ready), 352'(1));
                    check("rst_mid_overrun", 352'(overrun), 352'(0));
                end
            end
        end
        check("outputs_stable", 352'(unstable), 352'(0));
        if (rst_at >= 0) begin
            check("no_done_after_rst", 352'(done_at), 352'(-1));
            void'(sb.pop_front());
            model_reset();
        end else begin
            check("latency", 352'(done_at), 352'(33));
            if (sb.size() == 0) begin
                check("sb_nonempty", 352'(0), 352'(1));
            end else begin
                exp = sb.pop_front();
                check("frame_x", w_all_x, exp.x);
                check("frame_cnt", 352'(w_all_cnt), 352'(exp.cnt));
            end
            @(negedge Clk);
            check("done_pulse_1cyc", 352'(update_done), 352'(0));
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        logic [351:0] exp_y;
        bit extra;
        vecs[0] = '{lane: 0, speed: 3, dir: 0, count: 4, spacing: 160, ticks: 1, exp_cnt: 4,
                    exp_x: {11'd483, 11'd323, 11'd163, 11'd3}};
        vecs[1] = '{lane: 1, speed: 2, dir: 1, count: 7, spacing: 100, ticks: 1, exp_cnt: 4,
                    exp_x: {11'd298, 11'd198, 11'd98, 11'd2046}};
        vecs[2] = '{lane: 5, speed: 0, dir: 0, count: 2, spacing: 50, ticks: 2, exp_cnt: 2,
                    exp_x: {11'd150, 11'd100, 11'd50, 11'd0}};
        vecs[3] = '{lane: 7, speed: 15, dir: 1, count: 3, spacing: 255, ticks: 1, exp_cnt: 3,
                    exp_x: {11'd750, 11'd495, 11'd240, 11'd2033}};
        vecs[4] = '{lane: 3, speed: 5, dir: 0, count: 0, spacing: 200, ticks: 1, exp_cnt: 0,
                    exp_x: {11'd605, 11'd405, 11'd205, 11'd5}};
        vecs[5] = '{lane: 6, speed: 8, dir: 0, count: 4, spacing: 240, ticks: 1, exp_cnt: 4,
                    exp_x: {11'd8, 11'd488, 11'd248, 11'd8}};

        Reset = 1'b0; frame_tick = 1'b0; pause = 1'b0; cfg_we = 1'b0; cfg_lane = '0;
        cfg_speed = '0; cfg_dir = 1'b0; cfg_count = '0; cfg_spacing = '0;

        do_reset();
        exp_y = '0;
        for (int l = 0; l < 8; l++)
            for (int s = 0; s < 4; s++) exp_y[l*44 + s*11 +: 11] = 11'(360 - 40 * l);
        check("reset_x", w_all_x, '0);
        check("reset_cnt", 352'(w_all_cnt), '0);
        check("y_consts", w_all_y, exp_y);
        check("reset_ready", 352'(cfg_ready), 352'(1));
        check("reset_done", 352'(update_done), 352'(0));
        check("reset_overrun", 352'(overrun), 352'(0));

        repeat (3) run_frame(1'b0, -1, -1, -1);

        foreach (vecs[i]) begin
            do_reset();
            apply_cfg(vecs[i].lane, vecs[i].speed, vecs[i].dir, vecs[i].count,
                      vecs[i].spacing, 1'b0);
            repeat (vecs[i].ticks) run_frame(1'b0, -1, -1, -1);
            check("vec_lane_x", 352'(w_all_x[vecs[i].lane*44 +: 44]), 352'(vecs[i].exp_x));
            check("vec_lane_cnt", 352'(w_all_cnt[vecs[i].lane*3 +: 3]), 352'(vecs[i].exp_cnt));
        end

        // Walk lane0 slot2 to 638 and lane1 slot1 to -80, then step across the wrap.
        do_reset();
        apply_cfg(0, 3, 0, 4, 253, 1'b0);
        apply_cfg(1, 2, 1, 4, 8, 1'b0);
        repeat (44) run_frame(1'b0, -1, -1, -1);
        check("pre_wrap_right", 352'(Car_Row1_X[2]), 352'(638));
        check("pre_wrap_left", 352'(Car_Row2_X[1]), 352'(1968));
        run_frame(1'b0, -1, -1, -1);
        check("wrap_right", 352'(Car_Row1_X[2]), 352'(1969));
        check("wrap_left", 352'(Car_Row2_X[1]), 352'(638));

        run_frame(1'b0, 10, 5, -1);
        check("overrun_set", 352'(overrun), 352'(1));
        extra = 1'b0;
        repeat (40) begin
            @(negedge Clk);
            if (update_done) extra = 1'b1;
        end
        check("single_done", 352'(extra), 352'(0));

        run_frame(1'b1, -1, -1, -1);
        check("overrun_sticky", 352'(overrun), 352'(1));

        do_reset();
        apply_cfg(4, 6, 0, 4, 100, 1'b1);
        extra = 1'b0;
        repeat (40) begin
            @(negedge Clk);
            if (update_done) extra = 1'b1;
        end
        check("tick_dropped", 352'(extra), 352'(0));
        check("tick_drop_overrun", 352'(overrun), 352'(0));
        check("tick_drop_x", w_all_x, model_x());

        run_frame(1'b0, -1, -1, 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
